// File: rtl/streaming_max_pool2d.sv
// streaming_max_pool2d: non-overlapping KERNEL_HEIGHT x KERNEL_WIDTH max pool over a raster pixel stream.
// Latency: a pooled pixel is presented 1 cycle after the input beat that completes its window.
// Backpressure: one-deep output register; data_in_0_ready = !data_out_0_valid | data_out_0_ready.
//
// Ports:
//   clk, rst           rising-edge clock; synchronous active-low reset
//   data_in_0          one input pixel, CHANNELS lanes of P0 bits, lane 0 in the LSBs
//   data_in_0_valid    input beat valid
//   data_in_0_ready    input beat accepted when valid & ready
//   data_out_0         one pooled pixel, same lane packing as the input
//   data_out_0_valid   output beat valid (held with data until taken)
//   data_out_0_ready   downstream ready
//
// Only one row of partial window maxima (OUT_WIDTH x CHANNELS) is stored. Columns and rows that
// do not fill a whole window are accepted and counted but never touch the accumulator.
module streaming_max_pool2d #(
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int DATA_IN_0_PRECISION_1 = 3,
  parameter int CHANNELS              = 4,
  parameter int IN_WIDTH              = 8,
  parameter int IN_HEIGHT             = 8,
  parameter int KERNEL_WIDTH          = 2,
  parameter int KERNEL_HEIGHT         = 2,
  parameter int SIGNED                = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [DATA_IN_0_PRECISION_0*CHANNELS-1:0] data_in_0,
  input  logic                                      data_in_0_valid,
  output logic                                      data_in_0_ready,
  output logic [DATA_IN_0_PRECISION_0*CHANNELS-1:0] data_out_0,
  output logic                                      data_out_0_valid,
  input  logic                                      data_out_0_ready
);

  localparam int P0         = DATA_IN_0_PRECISION_0;
  localparam int DW         = P0 * CHANNELS;
  localparam int OUT_WIDTH  = IN_WIDTH / KERNEL_WIDTH;
  localparam int OUT_HEIGHT = IN_HEIGHT / KERNEL_HEIGHT;

  // Column-side counters can reach OUT_WIDTH (remainder columns), so size them for IN_WIDTH+1.
  localparam int CW  = $clog2(IN_WIDTH + 1);
  localparam int RW  = $clog2(IN_HEIGHT + 1);
  localparam int KXW = $clog2(KERNEL_WIDTH + 1);
  localparam int KYW = $clog2(KERNEL_HEIGHT + 1);
  localparam int AIW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [CW-1:0]  OCOL_END = CW'(OUT_WIDTH);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IN_HEIGHT - 1);
  localparam logic [RW-1:0]  OROW_END = RW'(OUT_HEIGHT);
  localparam logic [KXW-1:0] KX_LAST  = KXW'(KERNEL_WIDTH - 1);
  localparam logic [KYW-1:0] KY_LAST  = KYW'(KERNEL_HEIGHT - 1);

  // The fractional-bit count only describes the number format; max() is format-agnostic.
  if (KERNEL_WIDTH < 1 || KERNEL_HEIGHT < 1 || IN_WIDTH < KERNEL_WIDTH ||
      IN_HEIGHT < KERNEL_HEIGHT || CHANNELS < 1 || P0 < 1 ||
      DATA_IN_0_PRECISION_1 < 0 || DATA_IN_0_PRECISION_1 > P0) begin : g_bad_params
    $error("streaming_max_pool2d: illegal parameter combination");
  end

  logic [CW-1:0]  col_cnt;
  logic [CW-1:0]  ocol;
  logic [RW-1:0]  row_cnt;
  logic [RW-1:0]  orow;
  logic [KXW-1:0] kx;
  logic [KYW-1:0] ky;

  logic [P0-1:0]  acc [0:OUT_WIDTH-1][0:CHANNELS-1];

  logic           fire;
  logic           in_window;
  logic           first_elem;
  logic           win_done;
  logic           last_col;
  logic           last_row;
  logic [AIW-1:0] acc_idx;
  logic [DW-1:0]  pooled;

  function automatic logic [P0-1:0] lane_max(input logic [P0-1:0] a, input logic [P0-1:0] x);
    logic take_x;
    // Strictly greater: on a tie the stored value is kept.
    if (SIGNED != 0) take_x = $signed(x) > $signed(a);
    else             take_x = x > a;
    return take_x ? x : a;
  endfunction

  assign data_in_0_ready = !data_out_0_valid || data_out_0_ready;
  assign fire            = data_in_0_valid && data_in_0_ready;
  assign in_window       = (ocol < OCOL_END) && (orow < OROW_END);
  assign first_elem      = (kx == '0) && (ky == '0);
  assign win_done        = fire && in_window && (kx == KX_LAST) && (ky == KY_LAST);
  assign last_col        = (col_cnt == COL_LAST);
  assign last_row        = (row_cnt == ROW_LAST);
  assign acc_idx         = ocol[AIW-1:0];

  // Running window maximum including the current beat. The first element of a window loads
  // the pixel directly so stale contents from the previous window or frame never leak in.
  always_comb begin
    pooled = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (first_elem) pooled[c*P0 +: P0] = data_in_0[c*P0 +: P0];
      else            pooled[c*P0 +: P0] = lane_max(acc[acc_idx][c], data_in_0[c*P0 +: P0]);
    end
  end

  // Position counters and output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_cnt          <= '0;
      row_cnt          <= '0;
      kx               <= '0;
      ky               <= '0;
      ocol             <= '0;
      orow             <= '0;
      data_out_0       <= '0;
      data_out_0_valid <= 1'b0;
    end else begin
      if (fire) begin
        if (last_col) begin
          col_cnt <= '0;
          kx      <= '0;
          ocol    <= '0;
          if (last_row) begin
            row_cnt <= '0;
            ky      <= '0;
            orow    <= '0;
          end else begin
            row_cnt <= row_cnt + RW'(1);
            if (ky == KY_LAST) begin
              ky   <= '0;
              orow <= orow + RW'(1);
            end else begin
              ky <= ky + KYW'(1);
            end
          end
        end else begin
          col_cnt <= col_cnt + CW'(1);
          if (kx == KX_LAST) begin
            kx   <= '0;
            ocol <= ocol + CW'(1);
          end else begin
            kx <= kx + KXW'(1);
          end
        end
      end

      // win_done implies fire, which implies the output slot is free or being drained now,
      // so a new result may overwrite it in the same cycle.
      if (win_done) begin
        data_out_0       <= pooled;
        data_out_0_valid <= 1'b1;
      end else if (data_out_0_ready) begin
        data_out_0_valid <= 1'b0;
      end
    end
  end

  // Accumulator row: contents are don't-care across reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (fire && in_window) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc[acc_idx][c] <= pooled[c*P0 +: P0];
      end
    end
  end

endmodule
